// File: rtl/riscv_v_rf_wr_arbiter.sv
// Round-robin arbiter sharing the vector RF write port among NUM_REQ burst writers.
// Optional per-requester stall counters: define RISCV_V_RF_ARB_PERF_EN.
package riscv_v_rf_arb_pkg;
  typedef logic [4:0]  riscv_v_rf_addr_t;
  typedef logic [63:0] riscv_v_data_t;
  typedef logic [7:0]  riscv_v_rf_wr_en_t;

  typedef struct packed {
    riscv_v_rf_addr_t  addr;
    riscv_v_data_t     data;
    riscv_v_rf_wr_en_t be;
  } rf_wr_t;
endpackage

`ifdef RISCV_V_RF_ARB_PERF_EN
module riscv_v_rf_arb_stall_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  output logic [15:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                 cnt <= '0;
    else if (stall && cnt != '1) cnt <= cnt + 16'd1;
endmodule
`endif

module riscv_v_rf_wr_arbiter
  import riscv_v_rf_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int MAX_GRP = 8,
  parameter int LEN_W   = $clog2(MAX_GRP)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  riscv_v_rf_addr_t  [NUM_REQ-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][LEN_W-1:0]     req_len,
  input  riscv_v_data_t     [NUM_REQ-1:0]   req_data,
  input  riscv_v_rf_wr_en_t [NUM_REQ-1:0]   req_be,
  output riscv_v_rf_addr_t                  rf_wr_addr,
  output riscv_v_data_t                     rf_data_in,
  output riscv_v_rf_wr_en_t                 rf_wr_en,
  output logic                              busy,
  output logic                              err_misalign,
  output logic [NUM_REQ-1:0][15:0]          perf_stall_cnt
);
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int ADDR_W = $bits(riscv_v_rf_addr_t);

  typedef enum logic {IDLE, BURST} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d, owner_q, gnt_idx, sel;
  logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d, len_q;
  riscv_v_rf_addr_t   base_q, beat_addr;
  rf_wr_t             wr_q;
  logic               gnt_any, acc, first_beat, misalign;

  function automatic logic [IDX_W-1:0] nxt(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_REQ-1)) ? '0 : i + IDX_W'(1);
  endfunction

  // Mask of the next power of two >= len+1, so non-power-of-2 groups align to it.
  function automatic logic [LEN_W-1:0] smear(input logic [LEN_W-1:0] v);
    logic [LEN_W-1:0] m;
    m = v;
    for (int i = 1; i < LEN_W; i++) m = m | (v >> i);
    return m;
  endfunction

  // First valid requester at or after rr_ptr; descending scan lets the nearest win.
  always_comb begin
    int j;
    gnt_any = 1'b0;
    gnt_idx = '0;
    j       = 0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      j = int'(rr_ptr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req_valid[j]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
  end

  assign sel        = (state_q == IDLE) ? gnt_idx : owner_q;
  assign acc        = |(req_valid & req_ready);
  assign first_beat = acc && (state_q == IDLE);
  assign beat_addr  = (state_q == IDLE) ? req_addr[gnt_idx]
                                        : base_q + ADDR_W'(beat_cnt_q);
  assign misalign   = (req_addr[gnt_idx][LEN_W-1:0] & smear(req_len[gnt_idx])) != '0;
  assign busy       = (state_q == BURST);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    if (state_q == IDLE) begin
      if (acc) begin
        if (req_len[gnt_idx] == '0) rr_ptr_d = nxt(gnt_idx);
        else begin
          state_d    = BURST;
          beat_cnt_d = LEN_W'(1);
        end
      end
    end else if (acc) begin
      if (beat_cnt_q == len_q) begin
        state_d    = IDLE;
        rr_ptr_d   = nxt(owner_q);
        beat_cnt_d = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + LEN_W'(1);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE) begin
      if (gnt_any) req_ready[gnt_idx] = 1'b1;
    end else begin
      req_ready[owner_q] = req_valid[owner_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      base_q       <= '0;
      len_q        <= '0;
      owner_q      <= '0;
      wr_q         <= '0;
      err_misalign <= 1'b0;
    end else begin
      err_misalign <= first_beat && misalign;
      if (first_beat) begin
        base_q  <= req_addr[gnt_idx];
        len_q   <= req_len[gnt_idx];
        owner_q <= gnt_idx;
      end
      // Address and data hold across idle/stall cycles; only the enables drop.
      if (acc) wr_q <= '{addr: beat_addr, data: req_data[sel], be: req_be[sel]};
      else     wr_q.be <= '0;
    end

  assign rf_wr_addr = wr_q.addr;
  assign rf_data_in = wr_q.data;
  assign rf_wr_en   = wr_q.be;

`ifdef RISCV_V_RF_ARB_PERF_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_perf
    riscv_v_rf_arb_stall_cnt u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .stall (req_valid[i] && !req_ready[i]),
      .cnt   (perf_stall_cnt[i])
    );
  end
`else
  assign perf_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_riscv_v_rf_wr_arbiter.sv
// Scoreboard bench for riscv_v_rf_wr_arbiter: driver pushes expected writes, monitor pops on rf_wr_en.
module tb_riscv_v_rf_wr_arbiter;
  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [2:0]           req_valid = '0;
  logic [2:0]           req_ready;
  logic [2:0][4:0]      req_addr = '0;
  logic [2:0][2:0]      req_len = '0;
  logic [2:0][63:0]     req_data = '0;
  logic [2:0][7:0]      req_be = '0;
  logic [4:0]           rf_wr_addr;
  logic [63:0]          rf_data_in;
  logic [7:0]           rf_wr_en;
  logic                 busy, err_misalign;
  logic [2:0][15:0]     perf_stall_cnt;

  riscv_v_rf_wr_arbiter #(.NUM_REQ(3), .MAX_GRP(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len), .req_data(req_data), .req_be(req_be),
    .rf_wr_addr(rf_wr_addr), .rf_data_in(rf_data_in), .rf_wr_en(rf_wr_en),
    .busy(busy), .err_misalign(err_misalign), .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] a; logic [63:0] d; logic [7:0] be; logic err; } exp_t;
  exp_t        exp_q[$];
  int          n_cmp = 0, n_err = 0, seq = 0;
  int          stall_m[3] = '{0, 0, 0};
  logic        mon_en = 1'b0, prev_wr = 1'b0;
  logic [4:0]  last_a = '0;
  logic [63:0] last_d = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every registered write must match the oldest expected write.
  always @(negedge clk) if (mon_en) begin
    if (rf_wr_en != 8'h00) begin
      if (exp_q.size() == 0) chk("unexpected_write", {rf_wr_addr, rf_data_in, rf_wr_en}, 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("write", {rf_wr_addr, rf_data_in, rf_wr_en, err_misalign}, {e.a, e.d, e.be, e.err});
      end
    end else begin
      chk("err_without_write", err_misalign, 1'b0);
    end
  end

  // One clock of stimulus; wr is the requester whose beat should land at address a.
  task automatic cycle(input logic [2:0] v, input logic [2:0] rdy, input logic bsy,
                       input int wr, input logic [4:0] a, input logic err);
    seq++;
    req_valid = v;
    for (int i = 0; i < 3; i++) begin
      req_data[i] = 64'hD000_0000_0000_0000 | (64'(seq) << 8) | 64'(i);
      req_be[i]   = (i == 0) ? 8'hFF : (i == 1) ? (8'h81 | {4'h0, 4'(seq)}) : 8'h3C;
    end
    if (wr >= 0) exp_q.push_back('{a, req_data[wr], req_be[wr], err});
    @(negedge clk);
    chk("ready", req_ready, rdy);
    chk("busy", busy, bsy);
    if (!prev_wr) chk("hold", {rf_wr_addr, rf_data_in, rf_wr_en}, {last_a, last_d, 8'h00});
    prev_wr = (wr >= 0);
    if (wr >= 0) begin
      last_a = a;
      last_d = req_data[wr];
    end
    for (int i = 0; i < 3; i++) if (v[i] && !rdy[i]) stall_m[i]++;
    @(posedge clk); #1;
  endtask

  task automatic chk_perf();
    for (int i = 0; i < 3; i++) begin
`ifdef RISCV_V_RF_ARB_PERF_EN
      chk("perf_stall_cnt", perf_stall_cnt[i], 16'(stall_m[i]));
`else
      chk("perf_tied_zero", perf_stall_cnt[i], 16'h0);
`endif
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    req_valid = '0;
    #2;
    chk("rst_outputs", {rf_wr_addr, rf_data_in, rf_wr_en, err_misalign}, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", req_ready, 3'b000);
    stall_m = '{0, 0, 0};
    chk_perf();
    prev_wr = 1'b0;
    last_a  = '0;
    last_d  = '0;
    @(negedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    do_reset();

    // Single beat
    req_addr[0] = 5'd5; req_len[0] = 3'd0;
    cycle(3'b001, 3'b001, 0, 0, 5'd5, 0);
    cycle(3'b000, 3'b000, 0, -1, 0, 0);

    // Group of 4 from requester 1
    req_addr[1] = 5'd8; req_len[1] = 3'd3;
    for (int k = 0; k < 4; k++) cycle(3'b010, 3'b010, k > 0, 1, 5'(8 + k), 0);
    cycle(3'b000, 3'b000, 0, -1, 0, 0);
    // rr_ptr is now 2: requester 2 beats requester 0
    req_addr[0] = 5'd3; req_len[0] = 3'd0;
    req_addr[2] = 5'd7; req_len[2] = 3'd0;
    cycle(3'b101, 3'b100, 0, 2, 5'd7, 0);
    cycle(3'b001, 3'b001, 0, 0, 5'd3, 0);
    cycle(3'b000, 3'b000, 0, -1, 0, 0);

    // Contention from reset: order 0,1,2,0
    do_reset();
    req_addr = '{5'd4, 5'd2, 5'd0};
    req_len  = '{3'd1, 3'd1, 3'd1};
    cycle(3'b111, 3'b001, 0, 0, 5'd0, 0);
    cycle(3'b111, 3'b001, 1, 0, 5'd1, 0);
    cycle(3'b111, 3'b010, 0, 1, 5'd2, 0);
    cycle(3'b111, 3'b010, 1, 1, 5'd3, 0);
    cycle(3'b101, 3'b100, 0, 2, 5'd4, 0);
    cycle(3'b101, 3'b100, 1, 2, 5'd5, 0);
    req_addr[0] = 5'd6;
    cycle(3'b001, 3'b001, 0, 0, 5'd6, 0);
    cycle(3'b001, 3'b001, 1, 0, 5'd7, 0);
    cycle(3'b000, 3'b000, 0, -1, 0, 0);
    chk_perf();

    // Stall: requester 2 drops valid for 2 cycles, requester 0 waits
    req_addr[2] = 5'd12; req_len[2] = 3'd3;
    req_addr[0] = 5'd20; req_len[0] = 3'd0;
    cycle(3'b101, 3'b100, 0, 2, 5'd12, 0);
    cycle(3'b101, 3'b100, 1, 2, 5'd13, 0);
    cycle(3'b001, 3'b000, 1, -1, 0, 0);
    cycle(3'b001, 3'b000, 1, -1, 0, 0);
    cycle(3'b101, 3'b100, 1, 2, 5'd14, 0);
    cycle(3'b101, 3'b100, 1, 2, 5'd15, 0);
    cycle(3'b001, 3'b001, 0, 0, 5'd20, 0);
    cycle(3'b000, 3'b000, 0, -1, 0, 0);
    chk_perf();

    // Wrap and misalign
    req_addr[1] = 5'd30; req_len[1] = 3'd3;
    cycle(3'b010, 3'b010, 0, 1, 5'd30, 1);
    cycle(3'b010, 3'b010, 1, 1, 5'd31, 0);
    cycle(3'b010, 3'b010, 1, 1, 5'd0, 0);
    cycle(3'b010, 3'b010, 1, 1, 5'd1, 0);
    // Group of 3 aligns to 4: base 2 is misaligned
    req_addr[2] = 5'd2; req_len[2] = 3'd2;
    cycle(3'b100, 3'b100, 0, 2, 5'd2, 1);
    cycle(3'b100, 3'b100, 1, 2, 5'd3, 0);
    cycle(3'b100, 3'b100, 1, 2, 5'd4, 0);
    cycle(3'b000, 3'b000, 0, -1, 0, 0);

    // Reset mid-burst after beat 2 of 8
    req_addr[1] = 5'd16; req_len[1] = 3'd7;
    cycle(3'b010, 3'b010, 0, 1, 5'd16, 0);
    cycle(3'b010, 3'b010, 1, 1, 5'd17, 0);
    do_reset();
    req_addr[1] = 5'd9;  req_len[1] = 3'd0;
    req_addr[2] = 5'd10; req_len[2] = 3'd0;
    cycle(3'b110, 3'b010, 0, 1, 5'd9, 0);
    cycle(3'b100, 3'b100, 0, 2, 5'd10, 0);
    cycle(3'b000, 3'b000, 0, -1, 0, 0);
    chk_perf();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
